cint_sequencer: RTL and testbench

//   Multi-cycle sequencer for interrupt entry: services software CINT requests from the

---
 rtl/cint_sequencer.sv | 148 ++++++++++++++
 tb/tb_cint_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cint_sequencer.sv
// Interrupt-entry sequencer: arbitrates software CINT against masked hardware
// IRQs, pushes the PC (high then low byte), fetches the 2-byte vector from the
// IOP page (low then high byte), then loads the PC and clears IE in one cycle.
module cint_sequencer #(
  parameter int NUM_IRQ      = 4,
  parameter int IRQ_VEC_BASE = 8
) (
  input  logic               clk,
  input  logic               not_reset,
  input  logic               enable_cint,
  input  logic [3:0]         cint_vec,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               int_enable,
  input  logic               mem_ready,
  output logic               stall,
  output logic               busy,
  output logic               push_pc_hi,
  output logic               push_pc_lo,
  output logic               PA_Select_IOP_low,
  output logic               PA_Select_IOP_high,
  output logic [3:0]         vec_num,
  output logic               load_pc,
  output logic               clear_ie,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [NUM_IRQ-1:0] ACK_ONE = NUM_IRQ'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_HI  = 3'd1,
    PUSH_LO  = 3'd2,
    FETCH_LO = 3'd3,
    FETCH_HI = 3'd4,
    LOAD     = 3'd5
  } state_t;

  state_t             state;
  logic               sw_req;
  logic [IDX_W-1:0]   irq_idx;
  logic [NUM_IRQ-1:0] pend;
  logic [IDX_W-1:0]   pend_idx;
  logic               start;

  // Lowest-index pending hardware line wins the arbitration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pend     = irq & irq_mask & {NUM_IRQ{int_enable}};
    pend_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = IDX_W'(i);
    end
  end

  assign start = enable_cint | (|pend);

  // Fetch must freeze in the very cycle a request is accepted, hence combinational.
  assign stall = busy | ((state == IDLE) & start);

  // Sequencer state and registered strobes; each strobe is set on entry to its state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!not_reset) begin
      state              <= IDLE;
      vec_num            <= '0;
      sw_req             <= 1'b0;
      irq_idx            <= '0;
      busy               <= 1'b0;
      push_pc_hi         <= 1'b0;
      push_pc_lo         <= 1'b0;
      PA_Select_IOP_low  <= 1'b0;
      PA_Select_IOP_high <= 1'b0;
      load_pc            <= 1'b0;
      clear_ie           <= 1'b0;
      irq_ack            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_cint) begin
            vec_num    <= cint_vec;
            sw_req     <= 1'b1;
            state      <= PUSH_HI;
            busy       <= 1'b1;
            push_pc_hi <= 1'b1;
          end else if (|pend) begin
            vec_num    <= 4'(IRQ_VEC_BASE) + 4'(pend_idx);
            irq_idx    <= pend_idx;
            sw_req     <= 1'b0;
            state      <= PUSH_HI;
            busy       <= 1'b1;
            push_pc_hi <= 1'b1;
          end
        end
        PUSH_HI: begin
          if (mem_ready) begin
            state      <= PUSH_LO;
            push_pc_hi <= 1'b0;
            push_pc_lo <= 1'b1;
          end
        end
        PUSH_LO: begin
          if (mem_ready) begin
            state             <= FETCH_LO;
            push_pc_lo        <= 1'b0;
            PA_Select_IOP_low <= 1'b1;
          end
        end
        FETCH_LO: begin
          if (mem_ready) begin
            state              <= FETCH_HI;
            PA_Select_IOP_low  <= 1'b0;
            PA_Select_IOP_high <= 1'b1;
          end
        end
        FETCH_HI: begin
          if (mem_ready) begin
            state              <= LOAD;
            PA_Select_IOP_high <= 1'b0;
            load_pc            <= 1'b1;
            clear_ie           <= 1'b1;
            irq_ack            <= sw_req ? '0 : (ACK_ONE << irq_idx);
          end
        end
        LOAD: begin
          state    <= IDLE;
          busy     <= 1'b0;
          load_pc  <= 1'b0;
          clear_ie <= 1'b0;
          irq_ack  <= '0;
        end
        default: begin
          state              <= IDLE;
          busy               <= 1'b0;
          push_pc_hi         <= 1'b0;
          push_pc_lo         <= 1'b0;
          PA_Select_IOP_low  <= 1'b0;
          PA_Select_IOP_high <= 1'b0;
          load_pc            <= 1'b0;
          clear_ie           <= 1'b0;
          irq_ack            <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cint_sequencer.sv
// Self-checking bench for cint_sequencer: a phase-count reference model
// predicts every cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_cint_sequencer;

  localparam int NUM_IRQ      = 4;
  localparam int IRQ_VEC_BASE = 8;

  logic               clk = 1'b0;
  logic               not_reset;
  logic               enable_cint;
  logic [3:0]         cint_vec;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               int_enable;
  logic               mem_ready;
  logic               stall;
  logic               busy;
  logic               push_pc_hi;
  logic               push_pc_lo;
  logic               PA_Select_IOP_low;
  logic               PA_Select_IOP_high;
  logic [3:0]         vec_num;
  logic               load_pc;
  logic               clear_ie;
  logic [NUM_IRQ-1:0] irq_ack;

  always #5 clk = ~clk;

  cint_sequencer #(.NUM_IRQ(NUM_IRQ), .IRQ_VEC_BASE(IRQ_VEC_BASE)) dut (
    .clk                (clk),
    .not_reset          (not_reset),
    .enable_cint        (enable_cint),
    .cint_vec           (cint_vec),
    .irq                (irq),
    .irq_mask           (irq_mask),
    .int_enable         (int_enable),
    .mem_ready          (mem_ready),
    .stall              (stall),
    .busy               (busy),
    .push_pc_hi         (push_pc_hi),
    .push_pc_lo         (push_pc_lo),
    .PA_Select_IOP_low  (PA_Select_IOP_low),
    .PA_Select_IOP_high (PA_Select_IOP_high),
    .vec_num            (vec_num),
    .load_pc            (load_pc),
    .clear_ie           (clear_ie),
    .irq_ack            (irq_ack)
  );

  // Expected outputs for one clock cycle. strobes = {iop_high, iop_low, push_lo, push_hi}.
  typedef struct {
    logic               stall;
    logic               busy;
    logic [3:0]         strobes;
    logic               load;
    logic [3:0]         vec;
    logic [NUM_IRQ-1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   loads_seen = 0;

  // Reference model: phase 0 idle, 1..4 the four memory accesses in order, 5 load.
  int         m_phase = 0;
  logic [3:0] m_vec   = '0;
  int         m_src   = -1;   // -1 = software request, else serviced irq line

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lowest_set(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic cycle(input logic en, input logic [3:0] cv, input logic [NUM_IRQ-1:0] iq,
                       input logic [NUM_IRQ-1:0] mk, input logic ie, input logic mr,
                       input logic rn);
    exp_t e;
    int   pick;
    enable_cint = en;
    cint_vec    = cv;
    irq         = iq;
    irq_mask    = mk;
    int_enable  = ie;
    mem_ready   = mr;
    not_reset   = rn;
    pick      = lowest_set(iq & mk & {NUM_IRQ{ie}});
    e.busy    = (m_phase != 0);
    e.stall   = e.busy || en || (pick >= 0);
    e.strobes = '0;
    if (m_phase >= 1 && m_phase <= 4) e.strobes[m_phase-1] = 1'b1;
    e.load    = (m_phase == 5);
    e.vec     = m_vec;
    e.ack     = '0;
    if (m_phase == 5 && m_src >= 0) e.ack[m_src] = 1'b1;
    exp_q.push_back(e);
    if (!rn) begin
      m_phase = 0;
      m_vec   = '0;
      m_src   = -1;
    end else if (m_phase == 0) begin
      if (en) begin
        m_vec   = cv;
        m_src   = -1;
        m_phase = 1;
      end else if (pick >= 0) begin
        m_vec   = 4'(IRQ_VEC_BASE + pick);
        m_src   = pick;
        m_phase = 1;
      end
    end else if (m_phase == 5) begin
      m_phase = 0;
    end else if (mr) begin
      m_phase++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",   8'(stall), 8'(e.stall));
        check("busy",    8'(busy),  8'(e.busy));
        check("strobes", 8'({PA_Select_IOP_high, PA_Select_IOP_low, push_pc_lo, push_pc_hi}),
              8'(e.strobes));
        check("load_pc",  8'(load_pc),  8'(e.load));
        check("clear_ie", 8'(clear_ie), 8'(e.load));
        check("vec_num",  8'(vec_num),  8'(e.vec));
        check("irq_ack",  8'(irq_ack),  8'(e.ack));
        if (load_pc === 1'b1) loads_seen++;
      end
    end
  end

  initial begin
    not_reset   = 1'b0;
    enable_cint = 1'b0;
    cint_vec    = '0;
    irq         = '0;
    irq_mask    = '0;
    int_enable  = 1'b0;
    mem_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Post-reset quiet state.
    idle_cycles(2);

    // Disabled interrupts: global IE off, then all lines masked.
    repeat (4) cycle(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);

    // Software CINT 12 with memory always ready; noisy inputs while busy are ignored.
    cycle(1'b1, 4'd12, '0, '0, 1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 4'd3, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
    idle_cycles(3);

    // Hardware lines 1 and 2 pending: line 1 wins, vector 9.
    cycle(1'b0, 4'h0, 4'b0110, 4'hF, 1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b1);

    // Software and irq[0] together: software first, then irq[0] -> vector 8.
    cycle(1'b1, 4'd5, 4'b0001, 4'hF, 1'b1, 1'b1, 1'b1);
    repeat (7) cycle(1'b0, 4'h0, 4'b0001, 4'hF, 1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b1);

    // Memory wait states in PUSH_LO.
    cycle(1'b1, 4'd7, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10 && m_phase != 2; k++) idle_cycles(1);
    repeat (3) cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle_cycles(7);

    // Reset held three cycles in the middle of FETCH_LO aborts the sequence.
    cycle(1'b1, 4'd14, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10 && m_phase != 3; k++) idle_cycles(1);
    repeat (3) cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle_cycles(8);

    // Randomized traffic with occasional wait states and resets.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 15) == 0), 4'($urandom), NUM_IRQ'($urandom),
            NUM_IRQ'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) != 0));
    end
    idle_cycles(8);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    if (loads_seen == 0) begin
      fails++;
      $display("FAIL load_count: got 0 load_pc pulses, expected at least 1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
